// File: rtl/qspi_tx_shift.sv
// Quad SPI transmit serializer: loads a 32-bit word and shifts it out on 1/2/4 lanes per SCLK strobe.
// Latency: first beat one cycle after load; done_o pulses one cycle after the final strobe.
module qspi_tx_shift #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    len_i,
  input  logic [1:0]    mode_i,
  input  logic          lsb_first_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  input  logic          shift_en_i,
  input  logic          abort_i,
  output logic [3:0]    qsd_o,
  output logic [3:0]    qsd_oe_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [5:0] DW6 = 6'(DW);

  state_e        state_q, state_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [1:0]    lane_sh_q, lane_sh_d;
  logic          lsb_q, lsb_d;
  logic          done_q, done_d;

  // Load-time decode: lane_sh is log2(lanes), so beats = nbits >> lane_sh.
  logic [5:0]    nbits;
  logic [1:0]    lane_sh_in;
  logic [5:0]    beats;
  logic [DW-1:0] sr_load;

  always_comb begin
    nbits      = (len_i == 2'd0) ? DW6 : {1'b0, len_i, 3'b000};
    case (mode_i)
      2'b01:   lane_sh_in = 2'd1;
      2'b10:   lane_sh_in = 2'd2;
      default: lane_sh_in = 2'd0;
    endcase
    beats = nbits >> lane_sh_in;
    if (lsb_first_i) begin
      sr_load = data_i & ({DW{1'b1}} >> (DW6 - nbits));
    end else begin
      sr_load = data_i << (DW6 - nbits);
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    lane_sh_d = lane_sh_q;
    lsb_d     = lsb_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          state_d   = SHIFT;
          sr_d      = sr_load;
          cnt_d     = beats;
          lane_sh_d = lane_sh_in;
          lsb_d     = lsb_first_i;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end else if (shift_en_i) begin
          sr_d  = lsb_q ? (sr_q >> (3'd1 << lane_sh_q)) : (sr_q << (3'd1 << lane_sh_q));
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      lane_sh_q <= '0;
      lsb_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      lane_sh_q <= lane_sh_d;
      lsb_q     <= lsb_d;
      done_q    <= done_d;
    end
  end

  // Lanes are driven only while shifting; the pads float otherwise.
  always_comb begin
    qsd_o    = 4'b0000;
    qsd_oe_o = 4'b0000;
    if (state_q == SHIFT) begin
      case (lane_sh_q)
        2'd2: begin
          qsd_o    = lsb_q ? sr_q[3:0] : sr_q[DW-1:DW-4];
          qsd_oe_o = 4'b1111;
        end
        2'd1: begin
          qsd_o    = {2'b00, (lsb_q ? sr_q[1:0] : sr_q[DW-1:DW-2])};
          qsd_oe_o = 4'b0011;
        end
        default: begin
          qsd_o    = {3'b000, (lsb_q ? sr_q[0] : sr_q[DW-1])};
          qsd_oe_o = 4'b0001;
        end
      endcase
    end
  end

  assign load_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q == SHIFT);
  assign done_o       = done_q;

endmodule

// File: tb/tb_qspi_tx_shift.sv
// Directed bench for qspi_tx_shift with hand-computed beat sequences.
module tb_qspi_tx_shift;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  len_i = '0;
  logic [1:0]  mode_i = '0;
  logic        lsb_first_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic        shift_en_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [3:0]  qsd_o;
  logic [3:0]  qsd_oe_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  qspi_tx_shift dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .len_i(len_i), .mode_i(mode_i),
    .lsb_first_i(lsb_first_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .shift_en_i(shift_en_i), .abort_i(abort_i), .qsd_o(qsd_o), .qsd_oe_o(qsd_oe_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".qsd"}, 32'(qsd_o), 32'h0);
    chk({tag, ".oe"}, 32'(qsd_oe_o), 32'h0);
    chk({tag, ".busy"}, 32'(busy_o), 32'h0);
    chk({tag, ".ready"}, 32'(load_ready_o), 32'h1);
  endtask

  task automatic load(input logic [31:0] d, input logic [1:0] len, input logic [1:0] mode,
                      input logic lsb);
    data_i = d; len_i = len; mode_i = mode; lsb_first_i = lsb;
    load_valid_i = 1'b1;
    tick();
    load_valid_i = 1'b0;
    data_i = 32'hFFFF_FFFF; len_i = 2'd3; mode_i = 2'b11; lsb_first_i = ~lsb;
  endtask

  task automatic strobe();
    shift_en_i = 1'b1;
    tick();
    shift_en_i = 1'b0;
  endtask

  // seq holds one expected beat per nibble, first beat in the top nibble.
  task automatic run_beats(input string tag, input logic [31:0] seq, input int n,
                           input logic [3:0] oe);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.beat%0d", tag, k), 32'(qsd_o), 32'(seq[31-4*k -: 4]));
      if (k == 0) begin
        chk({tag, ".oe"}, 32'(qsd_oe_o), 32'(oe));
        chk({tag, ".ready_lo"}, 32'(load_ready_o), 32'h0);
        chk({tag, ".busy"}, 32'(busy_o), 32'h1);
      end
      strobe();
    end
    chk({tag, ".done"}, 32'(done_o), 32'h1);
    chk({tag, ".oe_off"}, 32'(qsd_oe_o), 32'h0);
    chk({tag, ".ready_hi"}, 32'(load_ready_o), 32'h1);
    tick();
    chk({tag, ".done_end"}, 32'(done_o), 32'h0);
  endtask

  initial begin
    #2;
    chk_idle("reset");
    chk("reset.done", 32'(done_o), 32'h0);
    rst_ni = 1'b1;
    tick();

    load(32'h1234_5678, 2'd0, 2'b10, 1'b0);
    run_beats("quad_msb", 32'h1234_5678, 8, 4'b1111);

    load(32'h1234_5678, 2'd0, 2'b10, 1'b1);
    run_beats("quad_lsb", 32'h8765_4321, 8, 4'b1111);

    load(32'hFFFF_FFA5, 2'd1, 2'b00, 1'b0);
    run_beats("single_msb", 32'h1010_0101, 8, 4'b0001);

    load(32'h0000_B4C3, 2'd2, 2'b01, 1'b0);
    run_beats("dual_msb", 32'h2310_3003, 8, 4'b0011);

    // Abort together with the third strobe.
    load(32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0);
    chk("abort.beat0", 32'(qsd_o), 32'hD);
    strobe();
    chk("abort.beat1", 32'(qsd_o), 32'hE);
    strobe();
    chk("abort.beat2", 32'(qsd_o), 32'hA);
    shift_en_i = 1'b1; abort_i = 1'b1;
    tick();
    shift_en_i = 1'b0; abort_i = 1'b0;
    chk_idle("abort");
    chk("abort.done", 32'(done_o), 32'h0);
    tick();
    chk("abort.done2", 32'(done_o), 32'h0);

    // Asynchronous reset mid-transfer.
    load(32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0);
    strobe();
    strobe();
    chk("rst.pre_busy", 32'(busy_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst.done", 32'(done_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("rst.done_after", 32'(done_o), 32'h0);

    // Back-to-back with load_valid held high.
    data_i = 32'h0000_00AB; len_i = 2'd1; mode_i = 2'b10; lsb_first_i = 1'b0;
    load_valid_i = 1'b1;
    tick();
    chk("b2b.beatA", 32'(qsd_o), 32'hA);
    chk("b2b.ready_lo", 32'(load_ready_o), 32'h0);
    strobe();
    chk("b2b.beatB", 32'(qsd_o), 32'hB);
    data_i = 32'h0000_00CD;
    strobe();
    chk("b2b.done", 32'(done_o), 32'h1);
    chk("b2b.ready_done", 32'(load_ready_o), 32'h1);
    tick();
    load_valid_i = 1'b0;
    chk("b2b.beatC", 32'(qsd_o), 32'hC);
    chk("b2b.busy2", 32'(busy_o), 32'h1);
    chk("b2b.done_lo", 32'(done_o), 32'h0);
    strobe();
    chk("b2b.beatD", 32'(qsd_o), 32'hD);
    strobe();
    chk("b2b.done2", 32'(done_o), 32'h1);
    tick();

    // Strobes while idle change nothing.
    shift_en_i = 1'b1;
    tick();
    tick();
    chk_idle("idle_shift");
    chk("idle_shift.done", 32'(done_o), 32'h0);
    shift_en_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_idle("idle_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qspi_tx_shift.md
Name: qspi_tx_shift

Overview:
- Transmit-side serializer for the Quad SPI datapath. It is the counterpart of the nibble-wide RX shift register.
- Accepts a 32-bit word through a valid/ready load handshake.
- Shifts the word out on 1, 2 or 4 IO lanes, MSB-first or LSB-first, advancing one beat per SCLK strobe from the clock generator.
- Drives the per-lane output enables for the IO pad tristates and pulses done when the last beat has been consumed.

Parameters:
- DW, 32, shift register width in bits. Fixed at 32; byte count logic depends on it.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- data_i  input  32  word to transmit; the low len bytes are used
- len_i  input  2  byte count; 1..3 = that many bytes, 0 = 4 bytes
- mode_i  input  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single
- lsb_first_i  input  1  1 = LSB-first order, 0 = MSB-first order
- load_valid_i  input  1  load request
- load_ready_o  output  1  block can accept a load
- shift_en_i  input  1  one-cycle strobe per SCLK shift edge
- abort_i  input  1  cancel the transfer in progress
- qsd_o  output  4  IO lane data
- qsd_oe_o  output  4  IO lane output enables
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse after the final beat

Behaviour:
- Reset (async) values:
  - state = IDLE
  - qsd_o = 0, qsd_oe_o = 0
  - busy_o = 0, done_o = 0
  - load_ready_o = 1
  - shift register = 0, beat counter = 0
- States: IDLE, SHIFT.
- load_ready_o = (state == IDLE). busy_o = (state == SHIFT).
- Handshake: the load fires when load_valid_i && load_ready_o at a clock edge. On that edge:
  - mode_i, lsb_first_i and len_i are latched.
  - nbits = 8*len, where len = 4 if len_i == 0.
  - lanes = 1 / 2 / 4 for single / dual / quad.
  - beats = nbits / lanes. Maximum is 32 (single, 4 bytes); minimum is 2 (quad, 1 byte). Beat counter is 6 bits.
  - MSB-first: sr = data_i << (32 - nbits), so the first bit sent is data_i[nbits-1].
  - LSB-first: sr = data_i, with unused upper bits masked to 0.
  - state -> SHIFT.
  - load_valid_i while not ready is ignored, with no side effects.
- Lane output (combinational from sr while in SHIFT):
  - MSB-first: single qsd_o[0] = sr[31]; dual qsd_o[1:0] = sr[31:30]; quad qsd_o[3:0] = sr[31:28].
  - LSB-first: single qsd_o[0] = sr[0]; dual qsd_o[1:0] = sr[1:0]; quad qsd_o[3:0] = sr[3:0].
  - Unused lanes drive 0.
  - The first beat is valid on the first cycle in SHIFT (one cycle after the handshake edge).
- qsd_oe_o in SHIFT: 4'b0001 single, 4'b0011 dual, 4'b1111 quad. In IDLE: 0000, and qsd_o = 0.
- Shift: on shift_en_i in SHIFT:
  - sr shifts by lanes (left for MSB-first, right for LSB-first, zero fill).
  - Beat counter decrements; the next beat appears the following cycle.
- Completion: a shift_en_i while beat counter == 1 moves state -> IDLE. done_o = 1 for exactly that next cycle; oe drops the same cycle.
- Back-to-back: a load is accepted in the done_o cycle (ready = 1). There is no idle gap beyond that cycle.
- shift_en_i in IDLE is ignored.
- abort_i in SHIFT: state -> IDLE next cycle, with no done_o, oe = 0 and the counter cleared. abort_i wins over a simultaneous shift_en_i. abort_i in IDLE has no effect. A simultaneous load_valid_i in IDLE is still accepted.
- Reset mid-transfer: all outputs return to reset values immediately (async) and no done_o is generated.
- Latched configuration is stable for the whole transfer; input changes during SHIFT have no effect.

Test Plan:
- Quad, MSB-first, len_i = 0, data 0x12345678:
  - qsd_o sequence 1,2,3,4,5,6,7,8 across 8 shift_en_i strobes; qsd_oe_o = 1111.
  - done_o pulses one cycle after the 8th strobe; load_ready_o is low during the transfer.
- Quad, LSB-first, len_i = 0, data 0x12345678: qsd_o sequence 8,7,6,5,4,3,2,1, then done_o.
- Single, MSB-first, len_i = 1, data 0xFFFFFFA5:
  - qsd_o[0] sequence 1,0,1,0,0,1,0,1; qsd_oe_o = 0001; qsd_o[3:1] = 0.
  - done_o after the 8th strobe.
- Dual, MSB-first, len_i = 2, data 0x0000B4C3: qsd_o[1:0] sequence 2,3,1,0,3,0,0,3; qsd_oe_o = 0011.
- Abort and reset:
  - Quad, 0xDEADBEEF: assert abort_i together with the 3rd shift_en_i. Next cycle state is IDLE, qsd_oe_o = 0, no done_o, load_ready_o = 1.
  - Repeat the transfer and drop rst_ni after 2 strobes. All outputs are 0 immediately.
- Back-to-back:
  - Hold load_valid_i high with quad 0x000000AB, len_i = 1: beats A,B, then done_o.
  - A second load of 0x000000CD is accepted in the done_o cycle, and its first beat C appears on the following cycle.
  - shift_en_i pulses while IDLE leave all outputs unchanged.
